// File: rtl/serial_subtractor.sv
// Bit-serial ripple subtractor: d = x - y - b_in, one bit per clock, LSB first.
// start/busy/done handshake; result registers update only when entering DONE.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             b_out
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sx;
   logic [WIDTH-1:0] sy;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic             bor;

   logic             a;
   logic             b;
   logic             diff;
   logic             bor_nx;
   logic             last;
   logic [WIDTH-1:0] sr_nx;

   // One full-subtractor slice on the current operand LSBs
   always_comb begin
      a      = sx[0];
      b      = sy[0];
      diff   = a ^ b ^ bor;
      bor_nx = (~a & b) | (~(a ^ b) & bor);
      last   = (cnt == CW'(WIDTH - 1));
   end

   // New difference bit enters the result register at the MSB end
   if (WIDTH == 1) begin : g_w1
      assign sr_nx = diff;
   end else begin : g_wn
      assign sr_nx = {diff, sr[WIDTH-1:1]};
   end

   // Control FSM, datapath shift registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sx    <= '0;
         sy    <= '0;
         sr    <= '0;
         cnt   <= '0;
         bor   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         d     <= '0;
         b_out <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state <= RUN;
                  sx    <= x;
                  sy    <= y;
                  bor   <= b_in;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               sr  <= sr_nx;
               sx  <= sx >> 1;
               sy  <= sy >> 1;
               bor <= bor_nx;
               cnt <= cnt + 1'b1;
               if (last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  d     <= sr_nx;
                  b_out <= bor_nx;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
